// File: rtl/aes_ser_pkg.sv
// Shared types and constants for the AES result serializer.
// The CRC state is only reachable when AES_SER_CRC_EN is defined.
package aes_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CRC  = 2'd2
  } ser_state_e;

  localparam int         DEFAULT_BLOCK_W = 128;
  localparam int         BYTES_PER_BLOCK = DEFAULT_BLOCK_W / 8;
  localparam logic [7:0] CRC8_POLY       = 8'h07;

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, MSB first, no reflection (polynomial from aes_ser_pkg).
module crc8_update
  import aes_ser_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] acc;

  always_comb begin
    acc = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (acc[7]) acc = {acc[6:0], 1'b0} ^ CRC8_POLY;
      else        acc = {acc[6:0], 1'b0};
    end
    crc_out = acc;
  end

endmodule

// File: rtl/aes_ct_serializer.sv
// Serializes a captured AES result block MSB-first onto a valid/ready byte stream.
// Define AES_SER_CRC_EN to append a CRC-8 trailer byte to every frame.
module aes_ct_serializer
  import aes_ser_pkg::*;
#(
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLOCK_W-1:0] result,
  input  logic               result_valid,
  output logic [7:0]         tdata,
  output logic               tvalid,
  input  logic               tready,
  output logic               tlast,
  output logic               busy,
  output logic               overrun
);

  // Handshake: a beat is a cycle with tvalid && tready; tdata/tlast/tvalid
  // hold while tvalid is high and tready is low.
  localparam int NBYTES = BLOCK_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rv_q;
  logic               armed_q;
  logic               ovr_q, ovr_d;

  logic capture, beat, last_data, final_beat, load;
  logic [7:0] data_byte;

  // armed_q blocks a level that was already high at reset release from
  // looking like a fresh rising edge.
  assign capture   = result_valid & ~rv_q & armed_q;
  assign data_byte = buf_q[BLOCK_W-1 -: 8];
  assign tvalid    = (state_q != ST_IDLE);
  assign busy      = tvalid;
  assign beat      = tvalid & tready;
  assign last_data = (state_q == ST_SEND) && (cnt_q == CNT_W'(NBYTES - 1));
  assign final_beat = beat & tlast;
  assign load      = capture & ((state_q == ST_IDLE) | final_beat);
  assign overrun   = ovr_q;

`ifdef AES_SER_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next;

  crc8_update u_crc (
    .crc_in  (crc_q),
    .data    (data_byte),
    .crc_out (crc_next)
  );

  assign tlast = (state_q == ST_CRC);
  assign tdata = (state_q == ST_CRC)  ? crc_q :
                 (state_q == ST_SEND) ? data_byte : 8'h00;

  always_comb begin
    crc_d = crc_q;
    if ((state_q == ST_SEND) && beat) crc_d = crc_next;
    if (load)                         crc_d = 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= 8'h00;
    else          crc_q <= crc_d;
  end
`else
  assign tlast = last_data;
  assign tdata = (state_q == ST_SEND) ? data_byte : 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (capture & tvalid & ~final_beat);
    if (load) begin
      buf_d   = result;
      cnt_d   = '0;
      state_d = ST_SEND;
    end else if (beat) begin
      if ((state_q == ST_SEND) && !last_data) begin
        buf_d = {buf_q[BLOCK_W-9:0], 8'h00};
        cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q == ST_SEND) begin
`ifdef AES_SER_CRC_EN
        state_d = ST_CRC;
`else
        state_d = ST_IDLE;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      armed_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rv_q    <= result_valid;
      armed_q <= armed_q | ~result_valid;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Randomized and directed bench for aes_ct_serializer against a byte-queue model.
module tb_aes_ct_serializer;

  localparam int BW = 128;
`ifdef AES_SER_CRC_EN
  localparam int FRAME_LEN = BW / 8 + 1;
`else
  localparam int FRAME_LEN = BW / 8;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BW-1:0] result;
  logic          result_valid;
  logic [7:0]    tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          busy;
  logic          overrun;

  aes_ct_serializer #(.BLOCK_W(BW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .result       (result),
    .result_valid (result_valid),
    .tdata        (tdata),
    .tvalid       (tvalid),
    .tready       (tready),
    .tlast        (tlast),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Model state: pending bytes of the current/next frame plus input history.
  logic [7:0] exp_q[$];
  logic       exp_ovr;
  logic       prev_rv;
  logic       armed;
  int         n_vec;
  int         n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic void push_frame(input logic [BW-1:0] blk);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int k = 0; k < BW / 8; k++) begin
      b = blk[BW-1-8*k -: 8];
      exp_q.push_back(b);
      c = crc8_ref(c, b);
    end
`ifdef AES_SER_CRC_EN
    exp_q.push_back(c);
`endif
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic tick();
    int  sz;
    logic ev, bt, rise;
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      exp_ovr = 1'b0;
      prev_rv = 1'b0;
      armed   = 1'b0;
    end
    ev = (exp_q.size() > 0);
    check("tvalid", tvalid, ev);
    check("busy", busy, ev);
    check("tlast", tlast, ev && exp_q.size() == 1);
    check("overrun", overrun, exp_ovr);
    if (ev)            check("tdata", tdata, exp_q[0]);
    else if (!reset_n) check("tdata_rst", tdata, 0);
    if (reset_n) begin
      sz   = exp_q.size();
      bt   = (sz > 0) && tready;
      rise = result_valid && !prev_rv && armed;
      if (bt) void'(exp_q.pop_front());
      if (rise) begin
        if (sz == 0 || (bt && sz == 1)) push_frame(result);
        else exp_ovr = 1'b1;
      end
      prev_rv = result_valid;
      armed   = armed | !result_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse(input logic [BW-1:0] blk);
    result       = blk;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  logic [BW-1:0] seq_blk;

  initial begin
    n_vec = 0; n_err = 0;
    exp_ovr = 1'b0; prev_rv = 1'b0; armed = 1'b0;
    reset_n = 1'b0; result_valid = 1'b0; tready = 1'b0; result = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // single frame, full throughput
    tready = 1'b1;
    pulse(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain(64);
    tick();

    // backpressure 1,0,0,1
    pulse({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      tready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    check("bp_drain", exp_q.size(), 0);
    tready = 1'b1;
    tick();

    // overrun: second rise while byte 5 is on the bus
    pulse({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 50 && (FRAME_LEN - exp_q.size()) < 5; i++) tick();
    pulse({$urandom, $urandom, $urandom, $urandom});
    drain(64);
    repeat (4) tick();
    check("overrun_sticky", overrun, 1);
    do_reset();

    // back-to-back: zeros block, then 00..0f coincident with the final beat
    pulse('0);
    for (int i = 0; i < 50 && exp_q.size() > 1; i++) tick();
    for (int k = 0; k < 16; k++) seq_blk[BW-1-8*k -: 8] = 8'(k);
    pulse(seq_blk);
    check("b2b_valid", tvalid, 1);
    drain(64);
    check("b2b_no_overrun", overrun, 0);
    tick();

    // reset at byte 8 with result_valid held high
    result       = {$urandom, $urandom, $urandom, $urandom};
    result_valid = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() == 0 || (FRAME_LEN - exp_q.size()) < 8); i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("rst_held_idle", busy, 0);
    result_valid = 1'b0;
    tick();
    pulse({$urandom, $urandom, $urandom, $urandom});
    drain(64);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) result_valid = ~result_valid;
      result = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
    end
    result_valid = 1'b0;
    tready       = 1'b1;
    drain(64);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_ct_serializer.md
AES_CT_SERIALIZER -- requirements
Module: aes_ct_serializer

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, width of the captured result block in bits; must be a multiple of 8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port result  input  BLOCK_W  AES core result block; sampled only on the capture cycle.
REQ-005 SHALL have port result_valid  input  1  AES core result-valid level; stays high while the result is valid.
REQ-006 SHALL have port tdata  output  8  serialized byte.
REQ-007 SHALL have port tvalid  output  1  tdata is valid.
REQ-008 SHALL have port tready  input  1  downstream (UART TX) accepts the byte.
REQ-009 SHALL have port tlast  output  1  marks the final byte of a frame.
REQ-010 SHALL have port busy  output  1  a frame is in progress.
REQ-011 SHALL have port overrun  output  1  sticky flag: a result was dropped.

Function
REQ-012 SHALL detect a capture event as a rising edge of result_valid, i.e. high this cycle and low in the previous registered sample.
REQ-013 SHALL register result into a BLOCK_W shift buffer on a capture event accepted in IDLE, and enter SEND.
REQ-014 SHALL assert tvalid in the cycle after capture, presenting byte 0 = result[BLOCK_W-1:BLOCK_W-8] (MSB first).
REQ-015 SHALL advance to the next byte only on a cycle with tvalid and tready both high; a beat is that handshake.
REQ-016 SHALL hold tdata, tlast and tvalid stable while tvalid is high and tready is low.
REQ-017 SHALL use states IDLE, SEND, and CRC (CRC only when the feature of REQ-027 is compiled in).
REQ-018 SHALL transition SEND->IDLE on the beat of byte BLOCK_W/8-1 when the CRC feature is absent, and assert tlast on that byte.
REQ-019 SHALL drive busy high exactly when the state is not IDLE, and tvalid low in IDLE.
REQ-020 SHALL accept a capture event coincident with the final beat of a frame, loading the new block and remaining in SEND with byte 0 valid on the next cycle (back-to-back, no idle gap).
REQ-021 SHALL, on a capture event while busy and not on the final beat, drop the new result, leave the current frame untouched, and set overrun.
REQ-022 SHALL keep overrun set until reset; it is not cleared by any other event.
REQ-023 SHALL ignore result_valid held high: no second capture without an intervening low cycle.

Reset
REQ-024 SHALL, while reset_n is low, force state IDLE and tdata=0, tvalid=0, tlast=0, busy=0, overrun=0, clear the byte counter, and clear the result_valid edge register.
REQ-025 SHALL abandon any partial frame on reset; no byte is resumed after reset release.
REQ-026 SHALL not treat result_valid already high at reset release as a capture event until it has been sampled low once.

Configuration
REQ-027 SHALL, when macro AES_SER_CRC_EN is defined, compute CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) over the BLOCK_W/8 data bytes.
REQ-028 SHALL, with AES_SER_CRC_EN defined, go SEND->CRC on the last data beat, send the CRC byte with tlast=1, then go CRC->IDLE on its beat; the REQ-020 back-to-back rule applies to the CRC beat.
REQ-029 SHALL, without AES_SER_CRC_EN, send only the data bytes, with no CRC logic or CRC state synthesized.

Structure
REQ-030 SHALL place the state enum typedef, BYTES_PER_BLOCK and CRC8_POLY in shared package aes_ser_pkg.
REQ-031 SHALL implement the per-byte CRC step as combinational sub-module crc8_update, with inputs crc_in[7:0] and data[7:0] and output crc_out[7:0], instantiated only under AES_SER_CRC_EN.

Verification
REQ-032 SHALL cover a single frame: result=128'h69c4e0d86a7b0430d8cdb78070b4c55a with a one-cycle rise and tready=1 -> 16 consecutive bytes 69,c4,...,5a, tlast on byte 15, busy low after it.
REQ-033 SHALL cover backpressure: tready toggling 1,0,0,1 during a frame -> each byte held stable while stalled, with no byte lost or duplicated.
REQ-034 SHALL cover overrun: a second rise at byte 5 -> the first frame completes intact, overrun=1 and stays 1, and no second frame is sent.
REQ-035 SHALL cover back-to-back: a second rise coincident with the final beat -> the next frame's byte 0 is valid on the following cycle and overrun=0.
REQ-036 SHALL cover reset mid-frame: reset_n pulsed low at byte 8 with result_valid held high -> all outputs 0, and no frame starts until result_valid falls and rises again.
REQ-037 SHALL cover CRC: with AES_SER_CRC_EN defined, 16 bytes of 00 -> 17th byte 00 with tlast; bytes 00..0f -> 17th byte equal to the CRC-8/0x07 reference-model value.
